// File: rtl/matmul_job_arbiter_if.sv
// -----------------------------------------------------------------------------
// matmul_job_arbiter_if
// Bundles the requester-side and multiplier-side signals of the shared 3x3
// matrix-multiply job arbiter.
//
//   Requester side : req_valid, req_A_flat, req_B_flat   (clients -> arbiter)
//                    req_grant, rsp_valid, rsp_error,
//                    rsp_C_flat, busy                     (arbiter -> clients)
//   Multiplier side: mm_start, mm_A_flat, mm_B_flat       (arbiter -> core)
//                    mm_C_flat, mm_done                   (core -> arbiter)
//
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (clients plus multiplier core)
// -----------------------------------------------------------------------------
interface matmul_job_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ELEM_W  = 8
);
    localparam int FLAT_W = 9 * ELEM_W;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*FLAT_W-1:0] req_A_flat;
    logic [NUM_REQ*FLAT_W-1:0] req_B_flat;
    logic [NUM_REQ-1:0]        req_grant;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic                      rsp_error;
    logic [FLAT_W-1:0]         rsp_C_flat;
    logic                      busy;
    logic                      mm_start;
    logic [FLAT_W-1:0]         mm_A_flat;
    logic [FLAT_W-1:0]         mm_B_flat;
    logic [FLAT_W-1:0]         mm_C_flat;
    logic                      mm_done;

    modport slave (
        input  req_valid, req_A_flat, req_B_flat, mm_C_flat, mm_done,
        output req_grant, rsp_valid, rsp_error, rsp_C_flat, busy,
               mm_start, mm_A_flat, mm_B_flat
    );

    modport master (
        output req_valid, req_A_flat, req_B_flat, mm_C_flat, mm_done,
        input  req_grant, rsp_valid, rsp_error, rsp_C_flat, busy,
               mm_start, mm_A_flat, mm_B_flat
    );
endinterface

// File: rtl/matmul_job_arbiter.sv
// -----------------------------------------------------------------------------
// matmul_job_arbiter
// Shares one 3x3 matrix-multiply core between NUM_REQ requesters. Pending jobs
// are arbitrated round-robin; the winner's operands are captured and the core
// is started. The result (or a timeout abort) is returned to the winner with a
// one-cycle response strobe.
//
// Ports:
//   clk    - clock, all logic on the rising edge
//   reset  - asynchronous, active-high reset
//   bus    - matmul_job_arbiter_if.slave (requester and multiplier signals)
//
// Parameters:
//   NUM_REQ - number of requesters (2..8)
//   ELEM_W  - bits per matrix element (flat matrix = 9*ELEM_W bits)
//   TIMEOUT - max cycles spent waiting for done before the job is aborted (>=2)
// -----------------------------------------------------------------------------
module matmul_job_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ELEM_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    matmul_job_arbiter_if.slave bus
);
    localparam int FLAT_W = 9 * ELEM_W;
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_winner;
    logic [WD_W-1:0]     r_wd;
    logic                r_done_q;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic                r_rsp_error;
    logic [FLAT_W-1:0]   r_rsp_c;
    logic                r_busy;
    logic                r_mm_start;
    logic [FLAT_W-1:0]   r_mm_a;
    logic [FLAT_W-1:0]   r_mm_b;

    logic                w_found;
    logic [IDX_W-1:0]    w_winner;
    logic [NUM_REQ-1:0]  w_win_oh;
    logic [NUM_REQ-1:0]  w_cur_oh;
    logic [FLAT_W-1:0]   w_sel_a;
    logic [FLAT_W-1:0]   w_sel_b;
    logic                w_done_rise;

    // Round-robin search: first pending requester at or after r_rr_ptr,
    // wrapping modulo NUM_REQ.
    always_comb begin
        int v_idx;
        v_idx    = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NUM_REQ) begin
                v_idx = v_idx - NUM_REQ;
            end
            if (!w_found && bus.req_valid[v_idx]) begin
                w_found  = 1'b1;
                w_winner = IDX_W'(v_idx);
            end
        end
    end

    assign w_win_oh    = NUM_REQ'(1) << w_winner;
    assign w_cur_oh    = NUM_REQ'(1) << r_winner;
    assign w_sel_a     = bus.req_A_flat[int'(w_winner)*FLAT_W +: FLAT_W];
    assign w_sel_b     = bus.req_B_flat[int'(w_winner)*FLAT_W +: FLAT_W];
    // Only a rising edge counts, so a done level left high by the previous
    // job is never mistaken for completion of the current one.
    assign w_done_rise = bus.mm_done & ~r_done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_winner    <= '0;
            r_wd        <= '0;
            r_done_q    <= 1'b0;
            r_grant     <= '0;
            r_rsp_valid <= '0;
            r_rsp_error <= 1'b0;
            r_rsp_c     <= '0;
            r_busy      <= 1'b0;
            r_mm_start  <= 1'b0;
            r_mm_a      <= '0;
            r_mm_b      <= '0;
        end else begin
            r_done_q    <= bus.mm_done;
            r_grant     <= '0;
            r_rsp_valid <= '0;
            r_mm_start  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_winner   <= w_winner;
                        r_grant    <= w_win_oh;
                        r_mm_a     <= w_sel_a;
                        r_mm_b     <= w_sel_b;
                        r_mm_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_START;
                    end
                end

                S_START: begin
                    r_wd    <= '0;
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    // Completion takes priority over a simultaneous timeout.
                    if (w_done_rise) begin
                        r_rsp_c     <= bus.mm_C_flat;
                        r_rsp_error <= 1'b0;
                        r_rsp_valid <= w_cur_oh;
                        r_state     <= S_RESP;
                    end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                        r_rsp_c     <= '0;
                        r_rsp_error <= 1'b1;
                        r_rsp_valid <= w_cur_oh;
                        r_state     <= S_RESP;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end

                S_RESP: begin
                    if (r_winner == IDX_W'(NUM_REQ - 1)) begin
                        r_rr_ptr <= '0;
                    end else begin
                        r_rr_ptr <= r_winner + 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_grant  = r_grant;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_error  = r_rsp_error;
    assign bus.rsp_C_flat = r_rsp_c;
    assign bus.busy       = r_busy;
    assign bus.mm_start   = r_mm_start;
    assign bus.mm_A_flat  = r_mm_a;
    assign bus.mm_B_flat  = r_mm_b;

endmodule
